// File: rtl/ct_split_pkg.sv
// Shared types for the packet-aware 1-to-NO splitter.
package ct_pkg;

    typedef enum logic {
        S_FIRST = 1'b0,
        S_BODY  = 1'b1
    } ct_split_state_t;

endpackage

// File: rtl/ct_bcast_tracker.sv
// Broadcast handshake tracker: remembers which outputs already took the
// current beat and releases the upstream beat once every selected output has it.
module ct_bcast_tracker #(
    parameter int NO = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_valid,
    input  logic [NO-1:0] cur_mask,
    input  logic [NO-1:0] i_ready,
    output logic [NO-1:0] o_valid,
    output logic          o_ready,
    output logic          xfer,
    output logic [NO-1:0] done
);

    logic [NO-1:0] done_reg;
    logic [NO-1:0] accept;

    genvar gi;
    generate
        for (gi = 0; gi < NO; gi++) begin : g_port
            // A port that already took the beat goes quiet while others stall.
            assign o_valid[gi] = reset_n & i_valid & cur_mask[gi] & ~done_reg[gi];
            assign accept[gi]  = o_valid[gi] & i_ready[gi];
        end
    endgenerate

    // Ready is independent of i_valid so upstream may wait for it.
    assign o_ready = reset_n & (&(done_reg | i_ready | ~cur_mask));
    assign xfer    = i_valid & o_ready;
    assign done    = done_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_reg <= '0;
        end else if (xfer) begin
            done_reg <= '0;
        end else begin
            done_reg <= done_reg | accept;
        end
    end

endmodule

// File: rtl/ct_split.sv
// Packet-aware 1-to-NO splitter: destination mask is latched on the first beat
// and held until eop; data and eop fan out combinationally to every port.
module ct_split
    import ct_pkg::*;
#(
    parameter int NO    = 2,
    parameter int WIDTH = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [WIDTH-1:0]    i_data,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_eop,
    input  logic [NO-1:0]       i_mask,
    output logic [NO*WIDTH-1:0] o_data,
    output logic [NO-1:0]       o_valid,
    input  logic [NO-1:0]       i_ready,
    output logic [NO-1:0]       o_eop
);

    ct_split_state_t state_reg;
    logic [NO-1:0]   mask_reg;
    logic [NO-1:0]   cur_mask;
    logic [NO-1:0]   done;
    logic            xfer;

    assign cur_mask = (state_reg == S_FIRST) ? i_mask : mask_reg;

    ct_bcast_tracker #(.NO(NO)) u_tracker (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_valid  (i_valid),
        .cur_mask (cur_mask),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .xfer     (xfer),
        .done     (done)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NO; gi++) begin : g_fanout
            assign o_data[gi*WIDTH +: WIDTH] = i_data;
            assign o_eop[gi]                 = i_eop;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_FIRST;
            mask_reg  <= '0;
        end else if (xfer) begin
            case (state_reg)
                S_FIRST: begin
                    if (!i_eop) begin
                        state_reg <= S_BODY;
                        mask_reg  <= i_mask;
                    end
                end
                S_BODY: begin
                    if (i_eop) begin
                        state_reg <= S_FIRST;
                    end
                end
                default: state_reg <= S_FIRST;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Once some outputs hold a first beat, re-steering it would corrupt delivery.
    a_mask_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (state_reg == S_FIRST && done != '0) |-> $stable(i_mask))
        else $error("ct_split: i_mask changed while first beat partially delivered");
`endif

endmodule

// File: doc/ct_split.md
Name: ct_split

Overview:
- Packet-aware 1-to-NO splitter/broadcaster; the fan-out counterpart of the NI-to-1 packet merge.
- Takes one valid/ready/eop stream plus a per-packet destination mask, and delivers each beat to every selected output.
- A beat is consumed upstream only once all selected outputs have accepted it.
- The destination mask is captured on the first beat and held until eop, so a packet never changes destination mid-flight.

Parameters:
NO, 2, number of output ports (>=1)
WIDTH, 1, data width per beat

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
i_data  input  WIDTH  input beat data
i_valid  input  1  input beat valid
o_ready  output  1  input beat consumed when i_valid && o_ready
i_eop  input  1  last beat of packet
i_mask  input  NO  destination mask, bit k selects output k; sampled only on first beat of a packet
o_data  output  NO*WIDTH  per-output data, slice k = i_data
o_valid  output  NO  per-output valid
i_ready  input  NO  per-output ready
o_eop  output  NO  per-output eop, each bit = i_eop

Behaviour:
- Interface (decided): one clock, clk; reset_n asynchronous, active-low.
- Datapath is combinational, zero latency; only control state is registered.
- State enum:
  - S_FIRST: next beat starts a packet.
  - S_BODY: mid-packet.
- Registers, reset values: state=S_FIRST, mask_q='0, done='0 (NO bits; outputs that already took the current beat).
- cur_mask = (state==S_FIRST) ? i_mask : mask_q.
- o_valid[k] = i_valid & cur_mask[k] & ~done[k]; forced to '0 while reset_n low.
- accept[k] = o_valid[k] & i_ready[k].
- o_ready = &(done | i_ready | ~cur_mask):
  - no combinational dependence on i_valid;
  - forced to 0 while reset_n low.
- xfer = i_valid & o_ready.
- done update:
  - done <= '0 on xfer;
  - else done <= done | accept.
- Each selected output sees each beat exactly once, with no duplicates under staggered ready.
- Simultaneous events:
  - If the last pending outputs accept in the same cycle, xfer occurs that cycle.
  - Outputs whose done bit is set show o_valid=0 even while other outputs stall.
- State transitions:
  - S_FIRST, xfer & !i_eop -> S_BODY, mask_q <= i_mask.
  - S_FIRST, xfer & i_eop -> stay in S_FIRST (single-beat packet).
  - S_BODY, xfer & i_eop -> S_FIRST.
  - All other cases hold state.
- i_mask is ignored in S_BODY.
- Zero mask: cur_mask == '0 gives o_valid='0 and o_ready=1, so the beat (or the whole packet) is dropped silently.
- Upstream rules:
  - i_data, i_eop and i_mask are stable while i_valid=1 and no xfer has occurred.
  - A mask change in S_FIRST with done != 0 is a protocol violation; flag it with a simulation-only assertion.
- Reset mid-packet:
  - All registers clear immediately.
  - The downstream packet is truncated; upstream and downstream are reset together.
- NO=1: degenerates to a pass-through gated by i_mask[0].

Decomposition:
- ct_pkg holds:
  - typedef enum ct_split_state_t {S_FIRST, S_BODY};
  - shared handshake helper constants, if any.
- One natural sub-module, ct_bcast_tracker (parameter NO). It holds the done register and produces o_valid, o_ready and xfer from i_valid, cur_mask and i_ready.
- The top level keeps the state machine, mask_q and the data/eop fan-out.

Test Plan:
NO=3, WIDTH=8 throughout.
1. Unicast single beat: mask=3'b010, data=8'hA5, eop=1, i_ready=3'b111 -> same cycle o_valid=3'b010, o_data slice1=8'hA5, o_ready=1; state stays S_FIRST.
2. Multicast, staggered ready: mask=3'b101, data=8'h3C, eop=1.
   - Cycle0, i_ready=3'b001 -> o_valid=3'b101, o_ready=0, done becomes 3'b001.
   - Cycle1, i_ready=3'b100 -> o_valid=3'b100, o_ready=1.
   - Output0 receives exactly one beat, output2 exactly one.
3. Mask lock: packet of 3 beats (11,22,33), first-beat mask=3'b001, i_mask driven to 3'b110 on beats 2-3, all ready -> all three beats appear only on output0 with o_eop[0] on 33. A following packet with mask 3'b110 appears on outputs 1 and 2.
4. Zero mask: mask=3'b000, i_valid=1, eop=1 -> o_valid=3'b000, o_ready=1, beat consumed, no downstream activity.
5. Backpressure: mask=3'b111, i_ready=3'b000 for 5 cycles, then 3'b111 -> o_ready=0 and o_valid=3'b111 held for 5 cycles; exactly one xfer on cycle 6.
6. Reset mid-packet: first beat non-eop transferred with mask 3'b011, then second beat with done=3'b001, then reset_n=0 -> o_valid=3'b000 and o_ready=0 during reset. After release, state=S_FIRST, done=0, and the next beat routes by fresh i_mask=3'b100.
